// File: rtl/hermes_pkg.sv
// Shared Hermes NoC constants and the local-port injector state encoding.
// Used by hermes_injector and its payload FIFO.
package hermes_pkg;

   localparam int FLIT_SIZE    = 32;
   localparam int NPORT        = 5;
   localparam int HERMES_LOCAL = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEAD    = 2'd1,
      SIZE    = 2'd2,
      PAYLOAD = 2'd3
   } inj_state_e;

   // Zero-extend a 16-bit routing address into a full flit.
   function automatic logic [FLIT_SIZE-1:0] addr_to_flit(input logic [15:0] addr);
      return {{(FLIT_SIZE-16){1'b0}}, addr};
   endfunction

endpackage

// File: rtl/hermes_injector_fifo.sv
// Synchronous payload FIFO for the Hermes injector; full/empty are registered
// and a write is refused while full even if a read happens on the same edge.
module hermes_injector_fifo
   import hermes_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FLIT_SIZE  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_i,
   input  logic [FLIT_SIZE-1:0] wr_data_i,
   input  logic                 rd_i,
   output logic [FLIT_SIZE-1:0] rd_data_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [FLIT_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic [CW-1:0]        w_count_nxt;
   logic                 r_full;
   logic                 r_empty;
   logic                 w_wr_acc;
   logic                 w_rd_acc;

   assign w_wr_acc  = wr_i && !r_full;
   assign w_rd_acc  = rd_i && !r_empty;
   assign rd_data_o = r_mem[r_rd_ptr];
   assign full_o    = r_full;
   assign empty_o   = r_empty;

   // Occupancy after this edge.
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = r_count - CW'(1);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Storage array.
   always_ff @(posedge clk_i) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
         r_empty <= (w_count_nxt == CW'(0));
      end
   end

endmodule

// File: rtl/hermes_injector.sv
// Hermes local-port packet injector: header, size and payload flits under credit flow control.
// Optional macro HERMES_INJECTOR_TIMESTAMP_EN prepends an accept-time cycle stamp to the payload.
module hermes_injector
   import hermes_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [15:0]          req_target_i,
   input  logic [CNT_W-1:0]     req_size_i,
   input  logic                 pl_valid_i,
   output logic                 pl_ready_o,
   input  logic [FLIT_SIZE-1:0] pl_data_i,
   output logic                 tx_o,
   input  logic                 credit_i,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     pkt_count_o
);

`ifdef HERMES_INJECTOR_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   inj_state_e           r_state;
   logic                 r_tx;
   logic [FLIT_SIZE-1:0] r_data;
   logic [CNT_W-1:0]     r_size;
   logic [CNT_W-1:0]     r_remaining;
   logic [CNT_W-1:0]     r_pkt_count;
   logic                 r_req_ready;
   logic                 r_busy;
   logic [FLIT_SIZE-1:0] w_ts;
   logic                 w_xfer;
   logic                 w_fifo_rd;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [FLIT_SIZE-1:0] w_fifo_data;

   hermes_injector_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FLIT_SIZE  (FLIT_SIZE)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (pl_valid_i),
      .wr_data_i (pl_data_i),
      .rd_i      (w_fifo_rd),
      .rd_data_o (w_fifo_data),
      .full_o    (w_fifo_full),
      .empty_o   (w_fifo_empty)
   );

`ifdef HERMES_INJECTOR_TIMESTAMP_EN
   logic [FLIT_SIZE-1:0] r_cycle;
   logic [FLIT_SIZE-1:0] r_ts;

   assign w_ts = r_ts;

   // Free-running cycle counter sampled at request accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + FLIT_SIZE'(1);
      end
   end

   // Stamp latch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ts <= '0;
      end else if ((r_state == IDLE) && req_valid_i && r_req_ready) begin
         r_ts <= r_cycle;
      end else begin
         r_ts <= r_ts;
      end
   end
`else
   assign w_ts = '0;
`endif

   assign w_xfer      = r_tx && credit_i;
   assign tx_o        = r_tx;
   assign data_o      = r_data;
   assign req_ready_o = r_req_ready;
   assign busy_o      = r_busy;
   assign pkt_count_o = r_pkt_count;
   assign pl_ready_o  = !w_fifo_full;

   // FIFO pop: only when a payload flit is about to be loaded into the output register.
   always_comb begin
      w_fifo_rd = 1'b0;
      case (r_state)
         SIZE: begin
            if (w_xfer && (r_size != '0) && !TS_EN) begin
               w_fifo_rd = !w_fifo_empty;
            end else begin
               w_fifo_rd = 1'b0;
            end
         end
         PAYLOAD: begin
            if (!r_tx) begin
               w_fifo_rd = !w_fifo_empty;
            end else if (w_xfer && (r_remaining != CNT_W'(1))) begin
               w_fifo_rd = !w_fifo_empty;
            end else begin
               w_fifo_rd = 1'b0;
            end
         end
         default: w_fifo_rd = 1'b0;
      endcase
   end

   // Packet FSM with registered flit, handshake and status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_tx        <= 1'b0;
         r_data      <= '0;
         r_size      <= '0;
         r_remaining <= '0;
         r_pkt_count <= '0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i && r_req_ready) begin
                  r_data      <= addr_to_flit(req_target_i);
                  r_size      <= req_size_i + CNT_W'(TS_EN);
                  r_tx        <= 1'b1;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= HEAD;
               end
            end
            HEAD: begin
               if (w_xfer) begin
                  r_data  <= FLIT_SIZE'(r_size);
                  r_state <= SIZE;
               end
            end
            SIZE: begin
               if (w_xfer) begin
                  if (r_size == '0) begin
                     r_tx        <= 1'b0;
                     r_pkt_count <= r_pkt_count + CNT_W'(1);
                     r_req_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_remaining <= r_size;
                     r_state     <= PAYLOAD;
                     if (TS_EN) begin
                        r_data <= w_ts;
                        r_tx   <= 1'b1;
                     end else if (w_fifo_rd) begin
                        r_data <= w_fifo_data;
                        r_tx   <= 1'b1;
                     end else begin
                        r_tx   <= 1'b0;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (w_xfer) begin
                  r_remaining <= r_remaining - CNT_W'(1);
                  if (r_remaining == CNT_W'(1)) begin
                     r_tx        <= 1'b0;
                     r_pkt_count <= r_pkt_count + CNT_W'(1);
                     r_req_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= IDLE;
                  end else if (w_fifo_rd) begin
                     r_data <= w_fifo_data;
                  end else begin
                     r_tx <= 1'b0;
                  end
               end else if (!r_tx && w_fifo_rd) begin
                  // Bubble refill: the FIFO just became non-empty.
                  r_data <= w_fifo_data;
                  r_tx   <= 1'b1;
               end
            end
            default: begin
               r_tx        <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hermes_injector.sv
// Directed and randomized bench for hermes_injector with a packet-level reference model.
module tb_hermes_injector;
   import hermes_pkg::*;

`ifdef HERMES_INJECTOR_TIMESTAMP_EN
   localparam int TS = 1;
`else
   localparam int TS = 0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [15:0] req_target_i;
   logic [15:0] req_size_i;
   logic        pl_valid_i;
   logic        pl_ready_o;
   logic [31:0] pl_data_i;
   logic        tx_o;
   logic        credit_i;
   logic [31:0] data_o;
   logic        busy_o;
   logic [15:0] pkt_count_o;

   hermes_injector #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_target_i (req_target_i),
      .req_size_i   (req_size_i),
      .pl_valid_i   (pl_valid_i),
      .pl_ready_o   (pl_ready_o),
      .pl_data_i    (pl_data_i),
      .tx_o         (tx_o),
      .credit_i     (credit_i),
      .data_o       (data_o),
      .busy_o       (busy_o),
      .pkt_count_o  (pkt_count_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Reference model: one packet in flight, payload stream as a queue.
   logic [31:0] q[$];
   bit          m_busy;
   int          m_phase;
   int          m_nfl;
   logic [15:0] m_target;
   logic [15:0] m_sizef;
   logic [31:0] m_ts;
   logic [31:0] m_cyc;
   logic [15:0] m_pkt;
   bit          push_exp;
   bit          prev_stall;
   logic [31:0] prev_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic see(input string tag, input logic etx, input logic [31:0] edata);
      chk({tag, ".tx"}, {31'b0, tx_o}, {31'b0, etx});
      if (etx) chk({tag, ".data"}, data_o, edata);
   endtask

   // Runs on the falling edge: inputs/outputs are stable for the coming rising edge.
   task automatic monitor();
      bit          acc;
      logic [31:0] e;
      if (rst_i) begin
         q.delete();
         m_busy     = 1'b0;
         m_phase    = 0;
         m_pkt      = 16'd0;
         m_cyc      = 32'd0;
         prev_stall = 1'b0;
      end else begin
         chk("busy", {31'b0, busy_o}, {31'b0, m_busy});
         chk("req_ready", {31'b0, req_ready_o}, {31'b0, !m_busy});
         chk("pkt_count", {16'b0, pkt_count_o}, {16'b0, m_pkt});
         if (!m_busy) chk("tx_idle", {31'b0, tx_o}, 32'd0);
         if (prev_stall) begin
            chk("stall_tx", {31'b0, tx_o}, 32'd1);
            chk("stall_data", data_o, prev_data);
         end
         prev_stall = tx_o && !credit_i;
         prev_data  = data_o;
         acc = req_valid_i && !m_busy;
         if (m_busy && (tx_o === 1'b1) && credit_i) begin
            if (m_phase == 0)                   e = {16'h0, m_target};
            else if (m_phase == 1)              e = {16'h0, m_sizef};
            else if (TS == 1 && m_phase == 2)   e = m_ts;
            else if (q.size() > 0)              e = q.pop_front();
            else                                e = 32'hDEAD_BEEF;
            chk("flit", data_o, e);
            m_phase++;
            if (m_phase == 2 + m_nfl) begin
               m_busy  = 1'b0;
               m_phase = 0;
               m_pkt   = m_pkt + 16'd1;
            end
         end
         if (acc) begin
            m_busy   = 1'b1;
            m_phase  = 0;
            m_target = req_target_i;
            m_sizef  = req_size_i + 16'(TS);
            m_nfl    = int'(m_sizef);
            m_ts     = m_cyc;
         end
         if (pl_valid_i && push_exp) begin
            chk("pl_ready", {31'b0, pl_ready_o}, 32'd1);
            q.push_back(pl_data_i);
         end
         m_cyc = m_cyc + 32'd1;
      end
   endtask

   task automatic cycle();
      @(negedge clk_i);
      monitor();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      pl_valid_i = 1'b1;
      pl_data_i  = d;
      push_exp   = 1'b1;
      cycle();
      pl_valid_i = 1'b0;
      push_exp   = 1'b0;
   endtask

   task automatic request(input logic [15:0] tgt, input logic [15:0] sz);
      req_valid_i  = 1'b1;
      req_target_i = tgt;
      req_size_i   = sz;
      cycle();
      req_valid_i  = 1'b0;
   endtask

   initial begin
      logic [31:0] t0;
      rst_i = 1'b1; req_valid_i = 1'b0; req_target_i = 16'd0; req_size_i = 16'd0;
      pl_valid_i = 1'b0; pl_data_i = 32'd0; credit_i = 1'b1; push_exp = 1'b0;
      m_busy = 1'b0; m_phase = 0; m_nfl = 0; m_pkt = 16'd0; m_cyc = 32'd0;
      m_target = 16'd0; m_sizef = 16'd0; m_ts = 32'd0; prev_stall = 1'b0; prev_data = 32'd0;
      cycle();
      cycle();
      rst_i = 1'b0;
      see("rst", 1'b0, 32'd0);
      chk("rst.data", data_o, 32'd0);
      chk("rst.req_ready", {31'b0, req_ready_o}, 32'd1);
      chk("rst.busy", {31'b0, busy_o}, 32'd0);
      chk("rst.pkt", {16'b0, pkt_count_o}, 32'd0);
      chk("rst.pl_ready", {31'b0, pl_ready_o}, 32'd1);

`ifndef HERMES_INJECTOR_TIMESTAMP_EN
      // Preloaded 3-flit packet, back-to-back.
      push(32'hAA01); push(32'hAA02); push(32'hAA03);
      request(16'h0102, 16'd3);
      see("t1.head", 1'b1, 32'h0000_0102); cycle();
      see("t1.size", 1'b1, 32'd3);         cycle();
      see("t1.p0", 1'b1, 32'hAA01);        cycle();
      see("t1.p1", 1'b1, 32'hAA02);        cycle();
      see("t1.p2", 1'b1, 32'hAA03);        cycle();
      see("t1.end", 1'b0, 32'd0);
      chk("t1.pkt", {16'b0, pkt_count_o}, 32'd1);
      chk("t1.req_ready", {31'b0, req_ready_o}, 32'd1);

      // Zero-length packet.
      request(16'h0000, 16'd0);
      see("t2.head", 1'b1, 32'd0); cycle();
      see("t2.size", 1'b1, 32'd0); cycle();
      see("t2.end", 1'b0, 32'd0);
      chk("t2.pkt", {16'b0, pkt_count_o}, 32'd2);
      chk("t2.busy", {31'b0, busy_o}, 32'd0);

      // Header held under credit back-pressure.
      credit_i = 1'b0;
      request(16'h0304, 16'd0);
      for (int i = 0; i < 4; i++) begin
         see("t3.stall", 1'b1, 32'h0000_0304);
         cycle();
      end
      see("t3.hold", 1'b1, 32'h0000_0304);
      credit_i = 1'b1;
      cycle();
      see("t3.size", 1'b1, 32'd0); cycle();
      see("t3.end", 1'b0, 32'd0);
      chk("t3.pkt", {16'b0, pkt_count_o}, 32'd3);

      // Payload starved: bubble until the first write.
      request(16'h0A0B, 16'd2);
      see("t4.head", 1'b1, 32'h0000_0A0B); cycle();
      see("t4.size", 1'b1, 32'd2);         cycle();
      see("t4.gap0", 1'b0, 32'd0);
      pl_valid_i = 1'b1; pl_data_i = 32'hBB01; push_exp = 1'b1;
      cycle();
      see("t4.gap1", 1'b0, 32'd0);
      pl_data_i = 32'hBB02;
      cycle();
      pl_valid_i = 1'b0; push_exp = 1'b0;
      see("t4.p0", 1'b1, 32'hBB01); cycle();
      see("t4.p1", 1'b1, 32'hBB02); cycle();
      see("t4.end", 1'b0, 32'd0);
      chk("t4.pkt", {16'b0, pkt_count_o}, 32'd4);

      // FIFO full: 8 accepted, 9th waits for a read.
      for (int i = 1; i <= 8; i++) begin
         push(32'hCC00 + 32'(i));
         chk("t5.pl_ready", {31'b0, pl_ready_o}, {31'b0, (i < 8)});
      end
      pl_valid_i = 1'b1; pl_data_i = 32'hCC09; push_exp = 1'b0;
      cycle();
      chk("t5.full_hold", {31'b0, pl_ready_o}, 32'd0);
      request(16'h0506, 16'd1);
      see("t5.head", 1'b1, 32'h0000_0506);
      chk("t5.full_a", {31'b0, pl_ready_o}, 32'd0);
      cycle();
      see("t5.size", 1'b1, 32'd1);
      chk("t5.full_b", {31'b0, pl_ready_o}, 32'd0);
      cycle();
      see("t5.p0", 1'b1, 32'hCC01);
      chk("t5.freed", {31'b0, pl_ready_o}, 32'd1);
      push_exp = 1'b1;
      cycle();
      pl_valid_i = 1'b0; push_exp = 1'b0;
      chk("t5.refull", {31'b0, pl_ready_o}, 32'd0);
      see("t5.end", 1'b0, 32'd0);
      chk("t5.pkt", {16'b0, pkt_count_o}, 32'd5);

      // Reset after one of four payload flits.
      request(16'h0007, 16'd4);
      see("t6.head", 1'b1, 32'h0000_0007); cycle();
      see("t6.size", 1'b1, 32'd4);         cycle();
      see("t6.p0", 1'b1, 32'hCC02);        cycle();
      see("t6.p1", 1'b1, 32'hCC03);
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      see("t6.rst", 1'b0, 32'd0);
      chk("t6.req_ready", {31'b0, req_ready_o}, 32'd1);
      chk("t6.pl_ready", {31'b0, pl_ready_o}, 32'd1);
      chk("t6.pkt", {16'b0, pkt_count_o}, 32'd0);
      chk("t6.busy", {31'b0, busy_o}, 32'd0);
      request(16'h0909, 16'd1);
      see("t6b.head", 1'b1, 32'h0000_0909); cycle();
      see("t6b.size", 1'b1, 32'd1);         cycle();
      see("t6b.empty", 1'b0, 32'd0);
      push(32'hDD01);
      see("t6b.wait", 1'b0, 32'd0);
      cycle();
      see("t6b.p0", 1'b1, 32'hDD01); cycle();
      see("t6b.end", 1'b0, 32'd0);
      chk("t6b.pkt", {16'b0, pkt_count_o}, 32'd1);
`else
      // Timestamp flit precedes the FIFO payload; size counts it.
      push(32'hEE01);
      t0 = m_cyc;
      request(16'h0101, 16'd1);
      see("ts.head", 1'b1, 32'h0000_0101); cycle();
      see("ts.size", 1'b1, 32'd2);         cycle();
      see("ts.stamp", 1'b1, t0);           cycle();
      see("ts.p0", 1'b1, 32'hEE01);        cycle();
      see("ts.end", 1'b0, 32'd0);
      chk("ts.pkt", {16'b0, pkt_count_o}, 32'd1);
`endif

      // Randomized traffic checked by the monitor's model.
      for (int i = 0; i < 1500; i++) begin
         credit_i     = ($urandom_range(0, 9) < 7);
         req_valid_i  = ($urandom_range(0, 3) == 0);
         req_target_i = 16'($urandom);
         req_size_i   = 16'($urandom_range(0, 5));
         if ((q.size() < 8) && ($urandom_range(0, 1) == 1)) begin
            pl_valid_i = 1'b1;
            pl_data_i  = $urandom;
            push_exp   = 1'b1;
         end else begin
            pl_valid_i = 1'b0;
            push_exp   = 1'b0;
         end
         cycle();
      end

      // Drain the packet in flight, bounded.
      req_valid_i = 1'b0;
      credit_i    = 1'b1;
      for (int i = 0; i < 300 && m_busy; i++) begin
         if (q.size() < 8) begin
            pl_valid_i = 1'b1;
            pl_data_i  = $urandom;
            push_exp   = 1'b1;
         end else begin
            pl_valid_i = 1'b0;
            push_exp   = 1'b0;
         end
         cycle();
      end
      pl_valid_i = 1'b0;
      push_exp   = 1'b0;
      cycle();
      chk("drain.busy", {31'b0, busy_o}, 32'd0);
      chk("drain.tx", {31'b0, tx_o}, 32'd0);
      chk("drain.pkt", {16'b0, pkt_count_o}, {16'b0, m_pkt});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
